// File: rtl/riscv_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package riscv_pkg;

   localparam int          XLEN             = 32;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries with a single-cycle flush.
module fetch_fifo #(
   parameter int  DEPTH   = 2,
   parameter type entry_t = riscv_pkg::fetch_entry_t
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  entry_t                   data_in,
   output entry_t                   head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;

   // Pointers are exactly log2(DEPTH) bits, so they wrap without extra logic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= data_in;
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, captures the imem word and queues {pc, instr} for decode.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        redirect_misaligned,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic [31:0] fetch_count
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   fetch_pc;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count;
   fetch_entry_t  entry_in;
   fetch_entry_t  head;

   // A redirect cycle blocks both ends so stale entries never reach decode.
   assign out_valid = (count != '0) && !redirect_valid;
   assign pop       = out_valid && out_ready;
   assign push      = fetch_en && !redirect_valid && (!full || pop);

   assign imem_pc        = fetch_pc;
   assign entry_in.pc    = fetch_pc;
   assign entry_in.instr = imem_instr;

   assign out_pc    = empty ? 32'h0000_0000 : head.pc;
   assign out_instr = empty ? NOP_INSTR     : head.instr;

   fetch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_valid),
      .data_in (entry_in),
      .head    (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc            <= RESET_PC;
         fetch_count         <= '0;
         redirect_misaligned <= 1'b0;
      end else begin
         redirect_misaligned <= redirect_valid && (redirect_target[1:0] != 2'b00);
         if (redirect_valid) begin
            fetch_pc <= {redirect_target[31:2], 2'b00};
         end else if (push) begin
            fetch_pc    <= fetch_pc + 32'd4;
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with an imem model returning 0x100+pc.
module tb_fetch_unit;
   import riscv_pkg::*;

   typedef struct packed {
      logic        en;
      logic        rdy;
      logic        rv;
      logic [31:0] tgt;
      logic        valid;
      logic [31:0] opc;
      logic [31:0] oins;
      logic [31:0] ipc;
      logic        mis;
      logic [31:0] cnt;
   } vec_t;

   localparam int NVEC = 22;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] imem_pc;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        redirect_misaligned;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] fetch_count;

   logic [31:0] w_imem_pc;
   logic [31:0] w_imem_instr;
   logic        w_mis;
   logic        w_valid;
   logic [31:0] w_out_pc;
   logic [31:0] w_out_instr;
   logic [31:0] w_count;
   logic        w_en;
   logic        w_rdy;
   logic        w_rv;
   logic [31:0] w_tgt;

   int errors;
   int checks;

   vec_t        vec [NVEC];
   logic [31:0] w_exp_ipc  [3];
   logic [31:0] w_exp_opc  [3];
   logic [31:0] w_exp_oins [3];
   logic        w_exp_val  [3];

   assign imem_instr   = imem_pc + 32'h100;
   assign w_imem_instr = w_imem_pc + 32'h100;

   fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .fetch_en            (fetch_en),
      .imem_pc             (imem_pc),
      .imem_instr          (imem_instr),
      .redirect_valid      (redirect_valid),
      .redirect_target     (redirect_target),
      .redirect_misaligned (redirect_misaligned),
      .out_valid           (out_valid),
      .out_ready           (out_ready),
      .out_pc              (out_pc),
      .out_instr           (out_instr),
      .fetch_count         (fetch_count)
   );

   // Second instance exercises the PC wrap from the top of the address space.
   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
      .clk                 (clk),
      .rst_n               (rst_n),
      .fetch_en            (w_en),
      .imem_pc             (w_imem_pc),
      .imem_instr          (w_imem_instr),
      .redirect_valid      (w_rv),
      .redirect_target     (w_tgt),
      .redirect_misaligned (w_mis),
      .out_valid           (w_valid),
      .out_ready           (w_rdy),
      .out_pc              (w_out_pc),
      .out_instr           (w_out_instr),
      .fetch_count         (w_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic applyStimulus(input vec_t v);
      fetch_en        = v.en;
      out_ready       = v.rdy;
      redirect_valid  = v.rv;
      redirect_target = v.tgt;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;

      vec[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13,  32'h0,   1'b0, 32'd0};
      vec[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   32'h100, 32'h4,   1'b0, 32'd1};
      vec[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   32'h104, 32'h8,   1'b0, 32'd2};
      vec[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h108, 32'hC,   1'b0, 32'd3};
      vec[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h108, 32'h10,  1'b0, 32'd4};
      vec[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h8,   32'h108, 32'h10,  1'b0, 32'd4};
      vec[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   32'h108, 32'h10,  1'b0, 32'd4};
      vec[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'hC,   32'h10C, 32'h14,  1'b0, 32'd5};
      vec[8]  = '{1'b1, 1'b1, 1'b1, 32'h200, 1'b0, 32'h10,  32'h110, 32'h18,  1'b0, 32'd6};
      vec[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13,  32'h200, 1'b0, 32'd6};
      vec[10] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 32'h300, 32'h204, 1'b0, 32'd7};
      vec[11] = '{1'b1, 1'b1, 1'b1, 32'h302, 1'b0, 32'h204, 32'h304, 32'h208, 1'b0, 32'd8};
      vec[12] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13,  32'h300, 1'b1, 32'd8};
      vec[13] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13,  32'h300, 1'b0, 32'd8};
      vec[14] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h300, 32'h400, 32'h304, 1'b0, 32'd9};
      vec[15] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h300, 32'h400, 32'h308, 1'b0, 32'd10};
      vec[16] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h304, 32'h404, 32'h308, 1'b0, 32'd10};
      vec[17] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13,  32'h308, 1'b0, 32'd10};
      vec[18] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13,  32'h308, 1'b0, 32'd10};
      vec[19] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h13,  32'h308, 1'b0, 32'd10};
      vec[20] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h308, 32'h408, 32'h30C, 1'b0, 32'd11};
      vec[21] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h308, 32'h408, 32'h310, 1'b0, 32'd12};

      w_exp_ipc[0] = 32'hFFFF_FFFC; w_exp_val[0] = 1'b0; w_exp_opc[0] = 32'h0;         w_exp_oins[0] = 32'h13;
      w_exp_ipc[1] = 32'h0000_0000; w_exp_val[1] = 1'b1; w_exp_opc[1] = 32'hFFFF_FFFC; w_exp_oins[1] = 32'h0000_00FC;
      w_exp_ipc[2] = 32'h0000_0004; w_exp_val[2] = 1'b1; w_exp_opc[2] = 32'h0;         w_exp_oins[2] = 32'h100;

      rst_n           = 1'b0;
      fetch_en        = 1'b0;
      out_ready       = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'h0;
      w_en            = 1'b1;
      w_rdy           = 1'b1;
      w_rv            = 1'b0;
      w_tgt           = 32'h0;

      #12;
      checkOutput("reset out_valid", 32'(out_valid), 32'h0);
      checkOutput("reset out_pc", out_pc, 32'h0);
      checkOutput("reset out_instr", out_instr, NOP_INSTR);
      checkOutput("reset imem_pc", imem_pc, 32'h0);
      checkOutput("reset fetch_count", fetch_count, 32'h0);
      checkOutput("reset misaligned", 32'(redirect_misaligned), 32'h0);

      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(vec[i]);
         #1;
         checkOutput($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vec[i].valid));
         checkOutput($sformatf("v%0d out_pc", i), out_pc, vec[i].opc);
         checkOutput($sformatf("v%0d out_instr", i), out_instr, vec[i].oins);
         checkOutput($sformatf("v%0d imem_pc", i), imem_pc, vec[i].ipc);
         checkOutput($sformatf("v%0d misaligned", i), 32'(redirect_misaligned), 32'(vec[i].mis));
         checkOutput($sformatf("v%0d fetch_count", i), fetch_count, vec[i].cnt);
         if (i < 3) begin
            checkOutput($sformatf("wrap%0d imem_pc", i), w_imem_pc, w_exp_ipc[i]);
            checkOutput($sformatf("wrap%0d out_valid", i), 32'(w_valid), 32'(w_exp_val[i]));
            checkOutput($sformatf("wrap%0d out_pc", i), w_out_pc, w_exp_opc[i]);
            checkOutput($sformatf("wrap%0d out_instr", i), w_out_instr, w_exp_oins[i]);
         end
         @(negedge clk);
      end

      // FIFO is full here; reset lands mid-phase, well away from any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async out_valid", 32'(out_valid), 32'h0);
      checkOutput("async imem_pc", imem_pc, 32'h0);
      checkOutput("async fetch_count", fetch_count, 32'h0);
      checkOutput("async out_instr", out_instr, NOP_INSTR);

      @(negedge clk);
      rst_n           = 1'b1;
      fetch_en        = 1'b1;
      out_ready       = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h500;
      #1;
      checkOutput("b2b first out_valid", 32'(out_valid), 32'h0);
      checkOutput("b2b first imem_pc", imem_pc, 32'h0);
      @(negedge clk);
      redirect_target = 32'h601;
      #1;
      checkOutput("b2b second imem_pc", imem_pc, 32'h500);
      checkOutput("b2b second misaligned", 32'(redirect_misaligned), 32'h0);
      @(negedge clk);
      redirect_valid = 1'b0;
      fetch_en       = 1'b0;
      #1;
      checkOutput("b2b final imem_pc", imem_pc, 32'h600);
      checkOutput("b2b final misaligned", 32'(redirect_misaligned), 32'h1);
      checkOutput("b2b final out_valid", 32'(out_valid), 32'h0);
      @(negedge clk);
      #1;
      checkOutput("b2b pulse cleared", 32'(redirect_misaligned), 32'h0);
      checkOutput("b2b held imem_pc", imem_pc, 32'h600);
      checkOutput("b2b fetch_count", fetch_count, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
